char_lcd_seq: RTL

//   Upstream sequencer for char_lcd_cont. Generates the 9-bit lcd_cnt step

---
 rtl/char_lcd_seq.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/char_lcd_seq.sv
// Step-code sequencer for char_lcd_cont: paces lcd_cnt through power-up, one init pass,
// then refresh passes (return-home + 32 chars) on request or continuously.
module char_lcd_seq #(
  parameter int unsigned STEP_DIV    = 50000,
  parameter int unsigned LONG_MULT   = 2,
  parameter int unsigned PWRUP_STEPS = 40
) (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic       start_i,
  input  logic       auto_refresh_i,
  output logic [8:0] lcd_cnt_o,
  output logic       busy_o,
  output logic       init_done_o,
  output logic       frame_done_o
);

  localparam int unsigned LongDwell = LONG_MULT * STEP_DIV;
  localparam int unsigned DwellW    = $clog2(LongDwell + 1);
  localparam int unsigned PwrW      = $clog2(PWRUP_STEPS + 1);

  localparam logic [8:0] CntFirst    = 9'h000;
  localparam logic [8:0] CntClrWait  = 9'h006;
  localparam logic [8:0] CntHome     = 9'h00A;
  localparam logic [8:0] CntHomeWait = 9'h00C;
  localparam logic [8:0] CntIdle     = 9'h04C;
  localparam logic [8:0] CntLast     = 9'h04D;

  localparam logic [DwellW-1:0] DwellShortLast = DwellW'(STEP_DIV - 1);
  localparam logic [DwellW-1:0] DwellLongLast  = DwellW'(LongDwell - 1);
  localparam logic [PwrW-1:0]   PwrLast        = PwrW'(PWRUP_STEPS - 1);

  typedef enum logic [1:0] {
    StPwrup,
    StInit,
    StIdle,
    StRefresh
  } state_e;

  state_e              state_q, state_d;
  logic [8:0]          cnt_q, cnt_d;
  logic [DwellW-1:0]   dwell_q, dwell_d;
  logic [PwrW-1:0]     pwr_q, pwr_d;
  logic                pending_q, pending_d;
  logic                init_done_q, init_done_d;
  logic                frame_done;
  logic                busy;
  logic                long_code;
  logic [DwellW-1:0]   dwell_last_val;
  logic                dwell_last;

  // Codes that follow Clear and Home need the longer LCD execution time.
  assign long_code      = (cnt_q == CntClrWait) || (cnt_q == CntHomeWait);
  assign dwell_last_val = long_code ? DwellLongLast : DwellShortLast;
  assign dwell_last     = (dwell_q >= dwell_last_val);
  assign busy           = (state_q != StIdle);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    dwell_d     = dwell_q;
    pwr_d       = pwr_q;
    pending_d   = pending_q | (start_i & busy);
    init_done_d = init_done_q;
    frame_done  = 1'b0;

    unique case (state_q)
      StPwrup: begin
        cnt_d = CntFirst;
        if (dwell_q >= DwellShortLast) begin
          dwell_d = '0;
          if (pwr_q >= PwrLast) begin
            pwr_d   = '0;
            state_d = StInit;
          end else begin
            pwr_d = pwr_q + PwrW'(1);
          end
        end else begin
          dwell_d = dwell_q + DwellW'(1);
        end
      end

      StInit, StRefresh: begin
        if (dwell_last) begin
          dwell_d = '0;
          if (cnt_q >= CntLast) begin
            frame_done = 1'b1;
            cnt_d      = CntIdle;
            state_d    = StIdle;
            if (state_q == StInit) begin
              init_done_d = 1'b1;
            end
          end else begin
            cnt_d = cnt_q + 9'd1;
          end
        end else begin
          dwell_d = dwell_q + DwellW'(1);
        end
      end

      StIdle: begin
        cnt_d   = CntIdle;
        dwell_d = '0;
        if (pending_q || start_i || auto_refresh_i) begin
          cnt_d     = CntHome;
          pending_d = 1'b0;
          state_d   = StRefresh;
        end
      end

      default: begin
        state_d = StPwrup;
        cnt_d   = CntFirst;
        dwell_d = '0;
        pwr_d   = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q     <= StPwrup;
      cnt_q       <= CntFirst;
      dwell_q     <= '0;
      pwr_q       <= '0;
      pending_q   <= 1'b0;
      init_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      dwell_q     <= dwell_d;
      pwr_q       <= pwr_d;
      pending_q   <= pending_d;
      init_done_q <= init_done_d;
    end
  end

  // A pass cut short by reset must not report completion.
  assign frame_done_o = frame_done & ~rst_i;
  assign lcd_cnt_o    = cnt_q;
  assign busy_o       = busy;
  assign init_done_o  = init_done_q;

endmodule
